// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit, requesting side of dmem.
// Optional macro LSU_MISALIGN_CHECK_EN: drop misaligned accesses.
module mem_stage_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_mem_memory_read,
  input  logic              ex_mem_memory_write,
  input  logic [2:0]        ex_mem_funct3,
  input  logic [63:0]       ex_mem_address,
  input  logic [63:0]       ex_mem_write_data,
  output logic              lsu_stall,
  output logic [63:0]       mem_wb_load_data,
  output logic              mem_wb_load_valid,
  output logic              lsu_misaligned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [63:0]       dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [63:0]       dmem_rdata
);

  localparam int AW = ADDR_W + 3;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT_R, DONE
  } state_t;

  typedef struct packed {
    logic          we;
    logic          mis;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
  } acc_t;

  state_t      state, state_d;
  acc_t        acc_q, acc_in;
  logic        go, mis, sx;
  logic [2:0]  lo_mask;
  logic [7:0]  strb;
  logic [63:0] ld_q, rsh, ext;
  logic        unused_addr_hi;

  assign go = ex_mem_memory_read | ex_mem_memory_write;
  assign unused_addr_hi = ^ex_mem_address[63:AW];

  // Alignment mask of the incoming access size
  always_comb begin
    lo_mask = 3'b000;
    unique case (ex_mem_funct3[1:0])
      2'd0: lo_mask = 3'b000;
      2'd1: lo_mask = 3'b001;
      2'd2: lo_mask = 3'b011;
      2'd3: lo_mask = 3'b111;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = |(ex_mem_address[2:0] & lo_mask);
`else
  assign mis = 1'b0;
`endif

  // Capture candidate: read wins, address aligned down to size
  always_comb begin
    acc_in.we    = ex_mem_memory_write & ~ex_mem_memory_read;
    acc_in.mis   = mis;
    acc_in.f3    = ex_mem_funct3;
    acc_in.addr  = {ex_mem_address[AW-1:3],
                    ex_mem_address[2:0] & ~lo_mask};
    acc_in.wdata = ex_mem_write_data;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:   if (go) state_d = mis ? DONE : REQ;
      REQ:    if (dmem_gnt)
                state_d = acc_q.we ? DONE : WAIT_R;
      WAIT_R: if (dmem_rvalid) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hold the accepted access for the whole transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      acc_q <= '0;
    else if (state == IDLE && go)
      acc_q <= acc_in;
  end

  // Pick the addressed lane and extend it per funct3
  always_comb begin
    rsh = dmem_rdata >> {acc_q.addr[2:0], 3'b000};
    sx  = ~acc_q.f3[2];
    ext = rsh;
    unique case (acc_q.f3[1:0])
      2'd0: ext = {{56{sx & rsh[7]}},  rsh[7:0]};
      2'd1: ext = {{48{sx & rsh[15]}}, rsh[15:0]};
      2'd2: ext = {{32{sx & rsh[31]}}, rsh[31:0]};
      2'd3: ext = rsh;
    endcase
  end

  // Load result register, held until the next load completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ld_q <= '0;
    else if (state == WAIT_R && dmem_rvalid)
      ld_q <= ext;
    else if (state == IDLE && go && mis &&
             ex_mem_memory_read)
      ld_q <= '0;
  end

  // Unshifted byte enables for the held access size
  always_comb begin
    strb = 8'h00;
    unique case (acc_q.f3[1:0])
      2'd0: strb = 8'h01;
      2'd1: strb = 8'h03;
      2'd2: strb = 8'h0f;
      2'd3: strb = 8'hff;
    endcase
  end

  // Per-state outputs
  always_comb begin
    lsu_stall         = 1'b0;
    mem_wb_load_valid = 1'b0;
    lsu_misaligned    = 1'b0;
    dmem_req          = 1'b0;
    dmem_we           = 1'b0;
    dmem_addr         = '0;
    dmem_wdata        = '0;
    dmem_wstrb        = '0;
    unique case (state)
      IDLE: lsu_stall = reset & go;
      REQ: begin
        lsu_stall  = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = acc_q.we;
        dmem_addr  = acc_q.addr[AW-1:3];
        dmem_wdata = acc_q.wdata <<
                     {acc_q.addr[2:0], 3'b000};
        dmem_wstrb = acc_q.we ?
                     strb << acc_q.addr[2:0] : 8'h00;
      end
      WAIT_R: lsu_stall = 1'b1;
      DONE: begin
        mem_wb_load_valid = ~acc_q.we;
        lsu_misaligned    = acc_q.mis;
      end
      default: lsu_stall = 1'b0;
    endcase
  end

  assign mem_wb_load_data = ld_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized scoreboard bench for mem_stage_lsu.
// Build with LSU_MISALIGN_CHECK_EN for both files to test that mode.
`timescale 1ns/1ps
module tb_mem_stage_lsu;

  localparam int AW = 10;
  localparam int NB = 8 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rd = 1'b0, wr = 1'b0;
  logic [2:0]    f3_in = '0;
  logic [63:0]   addr_in = '0, wd_in = '0;
  logic          lsu_stall, mem_wb_load_valid, lsu_misaligned;
  logic [63:0]   mem_wb_load_data;
  logic          dmem_req, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [63:0]   dmem_wdata;
  logic [7:0]    dmem_wstrb;
  logic          dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [63:0]   dmem_rdata = '0;

  mem_stage_lsu #(.ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .ex_mem_memory_read(rd),
    .ex_mem_memory_write(wr),
    .ex_mem_funct3(f3_in),
    .ex_mem_address(addr_in),
    .ex_mem_write_data(wd_in),
    .lsu_stall(lsu_stall),
    .mem_wb_load_data(mem_wb_load_data),
    .mem_wb_load_valid(mem_wb_load_valid),
    .lsu_misaligned(lsu_misaligned),
    .dmem_req(dmem_req),
    .dmem_we(dmem_we),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    logic [7:0]    wstrb;
  } req_t;

  int          checks = 0, failures = 0;
  byte unsigned ref_mem [NB];
  logic [63:0] mem [1 << AW];
  req_t        req_q [$];
  logic [63:0] load_q [$];
  int          exp_mis = 0;
  int          g_cnt = 0, rv_wait = 0, rv_cnt = 0;
  bit          pend_rv = 0;
  logic [AW-1:0] pend_addr = '0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // memory responder with programmable gnt / rvalid delays and noise
  initial begin
    forever begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b0;
      if (pend_rv) begin
        if (rv_cnt == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata = mem[pend_addr];
          pend_rv = 0;
        end else rv_cnt--;
      end else begin
        dmem_rvalid = ($urandom_range(0, 3) == 0);
        dmem_rdata = {$urandom, $urandom};
        if (dmem_req) begin
          if (g_cnt == 0) begin
            dmem_gnt = 1'b1;
            if (dmem_we) begin
              for (int b = 0; b < 8; b++)
                if (dmem_wstrb[b])
                  mem[dmem_addr][8*b +: 8] = dmem_wdata[8*b +: 8];
            end else begin
              pend_rv = 1;
              rv_cnt = rv_wait;
              pend_addr = dmem_addr;
            end
          end else g_cnt--;
        end else dmem_gnt = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents an output
  initial begin
    bit hold = 0;
    req_t prev, e;
    forever begin
      @(negedge clk);
      #2;
      if (hold && dmem_req) begin
        chk("req_stable_we", dmem_we, prev.we);
        chk("req_stable_addr", dmem_addr, prev.addr);
        chk("req_stable_wdata", dmem_wdata, prev.wdata);
        chk("req_stable_wstrb", dmem_wstrb, prev.wstrb);
      end
      hold = dmem_req && !dmem_gnt;
      prev = '{dmem_we, dmem_addr, dmem_wdata, dmem_wstrb};
      if (dmem_req && dmem_gnt) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 1, 0);
        end else begin
          e = req_q.pop_front();
          chk("req_we", dmem_we, e.we);
          chk("req_addr", dmem_addr, e.addr);
          chk("req_wstrb", dmem_wstrb, e.wstrb);
          if (e.we) chk("req_wdata", dmem_wdata, e.wdata);
        end
      end
      if (mem_wb_load_valid) begin
        if (load_q.size() == 0) chk("unexpected_load", 1, 0);
        else chk("load_data", mem_wb_load_data, load_q.pop_front());
      end
      if (lsu_misaligned) begin
        chk("misaligned_expected", exp_mis > 0, 1);
        if (exp_mis > 0) exp_mis--;
      end
    end
  end

  // one access through the pipeline, reference model predicts result
  task automatic issue(input bit r, input bit w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       input int gw, input int rw);
    int nb, ea, exp_st, st;
    bit mis, s, done;
    req_t e;
    logic [63:0] v;
    nb = 1 << f3[1:0];
    mis = (int'(a[2:0]) % nb) != 0;
`ifndef LSU_MISALIGN_CHECK_EN
    mis = 0;
`endif
    ea = (int'(a[AW+2:0]) / nb) * nb;
    if (mis) begin
      exp_mis++;
      if (r) load_q.push_back(64'd0);
      exp_st = 1;
    end else begin
      e.we = !r;
      e.addr = AW'(ea / 8);
      e.wdata = wd << (8 * (ea % 8));
      e.wstrb = 8'h00;
      if (r) begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[ea + i];
        if (!f3[2] && nb < 8 && v[8*nb - 1])
          for (int i = 8 * nb; i < 64; i++) v[i] = 1'b1;
        load_q.push_back(v);
        exp_st = 3 + gw + rw;
      end else begin
        for (int i = 0; i < nb; i++) begin
          e.wstrb[(ea % 8) + i] = 1'b1;
          ref_mem[ea + i] = wd[8*i +: 8];
        end
        exp_st = 2 + gw;
      end
      req_q.push_back(e);
    end
    g_cnt = gw;
    rv_wait = rw;
    rd = r; wr = w; f3_in = f3; addr_in = a; wd_in = wd;
    st = 0;
    done = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      s = lsu_stall;
      @(negedge clk);
      if (!s) done = 1;
      else st++;
    end
    rd = 0; wr = 0;
    chk("access_timeout", done, 1);
    chk("stall_cycles", st, exp_st);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_stall"}, lsu_stall, 0);
    chk({tag, "_ldata"}, mem_wb_load_data, 0);
    chk({tag, "_lvalid"}, mem_wb_load_valid, 0);
    chk({tag, "_misal"}, lsu_misaligned, 0);
    chk({tag, "_req"}, dmem_req, 0);
    chk({tag, "_we"}, dmem_we, 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_wstrb"}, dmem_wstrb, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r64;
    req_t e;
    for (int w = 0; w < (1 << AW); w++) begin
      r64 = {$urandom, $urandom};
      mem[w] = r64;
      for (int b = 0; b < 8; b++) ref_mem[w*8 + b] = r64[8*b +: 8];
    end
    rd = 1; wr = 1; f3_in = 3'b011; addr_in = 64'h48; wd_in = '1;
    #12;
    chk_all_zero("reset");
    rd = 0; wr = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    issue(0, 1, 3'b011, 64'h40, 64'h1122334455667788, 0, 0);
    issue(1, 0, 3'b011, 64'h40, 64'd0, 0, 0);
    chk("ld_sd_back", mem_wb_load_data, 64'h1122334455667788);
    issue(0, 1, 3'b000, 64'h43, 64'h00000000000000ab, 0, 0);
    issue(1, 0, 3'b100, 64'h43, 64'd0, 1, 2);
    chk("lbu_43", mem_wb_load_data, 64'h00000000000000ab);
    issue(0, 1, 3'b011, 64'h40, 64'h0000000080000000, 0, 0);
    issue(1, 0, 3'b000, 64'h43, 64'd0, 0, 0);
    chk("lb_43", mem_wb_load_data, 64'hffffffffffffff80);
    issue(1, 0, 3'b010, 64'h44, 64'd0, 0, 1);
    chk("lw_44", mem_wb_load_data, 64'h0000000000000000);
    issue(0, 1, 3'b011, 64'h48, 64'hdeadbeefcafef00d, 5, 0);
    issue(1, 0, 3'b010, 64'h42, 64'd0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_42", mem_wb_load_data, 64'h0000000000000000);
`else
    chk("lw_42", mem_wb_load_data, 64'hffffffff80000000);
`endif
    issue(1, 0, 3'b011, 64'h48, 64'd0, 2, 3);
    chk("ld_48", mem_wb_load_data, 64'hdeadbeefcafef00d);

    // reset while waiting for read data
    e.we = 0; e.addr = AW'(8); e.wdata = '0; e.wstrb = 8'h00;
    req_q.push_back(e);
    g_cnt = 0; rv_wait = 4;
    rd = 1; f3_in = 3'b011; addr_in = 64'h40;
    @(negedge clk);
    @(negedge clk);
    rd = 0;
    #1;
    chk("waitr_stall", lsu_stall, 1);
    reset = 0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    #1;
    chk_all_zero("midreset_next");
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk("late_rvalid_valid", mem_wb_load_valid, 0);
      chk("late_rvalid_data", mem_wb_load_data, 0);
    end

    for (int n = 0; n < 250; n++) begin
      logic [63:0] a;
      int k;
      bit r, w;
      a = {$urandom, $urandom};
      a[12:0] = 13'($urandom_range(0, 255));
      k = $urandom_range(0, 2);
      r = (k != 1);
      w = (k != 0);
      issue(r, w, 3'($urandom_range(0, 7)), a, {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("req_q_empty", req_q.size(), 0);
    chk("load_q_empty", load_q.size(), 0);
    chk("mis_pending", exp_mis, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
